deck_shuffler: RTL

//  Shuffles the 52-card deck held in the shared 64x6 deck RAM with a Fisher-Yates pass. It first writes
//  the ordered deck (card k at address k), then performs random swaps driven by a free-running LFSR.
//  Its address, write and ownership outputs feed the memory-access multiplexer in front of the deck RAM.
//  The adder path reads the deck only after o_Done.

---
 rtl/deck_shuffler_if.sv | 16 +
 rtl/deck_shuffler.sv | 109 ++++++++++
 2 files changed

// File: rtl/deck_shuffler_if.sv
// deck_shuffler_if: deck RAM access bundle between the shuffler and the RAM/mux side
//   i_Start        start request into the shuffler
//   i_RdData       registered RAM read data into the shuffler
//   o_ShufflerAddr RAM address, o_WrData write data, o_WrEn write enable
//   o_ActShuffler  shuffler owns the RAM, o_Done completion pulse
interface deck_shuffler_if #(parameter int ADDR_W = 6);
  logic              i_Start;
  logic [ADDR_W-1:0] i_RdData;
  logic [ADDR_W-1:0] o_ShufflerAddr;
  logic [ADDR_W-1:0] o_WrData;
  logic              o_WrEn;
  logic              o_ActShuffler;
  logic              o_Done;
  modport master (input i_Start, i_RdData, output o_ShufflerAddr, o_WrData, o_WrEn, o_ActShuffler, o_Done);
  modport slave (output i_Start, i_RdData, input o_ShufflerAddr, o_WrData, o_WrEn, o_ActShuffler, o_Done);
endinterface

// File: rtl/deck_shuffler.sv
// deck_shuffler: writes the ordered deck into the deck RAM, then Fisher-Yates shuffles it using a free-running LFSR
//   i_Clk   clock (also clocks the deck RAM)
//   i_Reset asynchronous active-high reset
//   bus     deck_shuffler_if master: start/read data in, address/write/ownership/done out
module deck_shuffler #(
  parameter int          DECK_SIZE = 52,
  parameter int          ADDR_W    = 6,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input logic              i_Clk,
  input logic              i_Reset,
  deck_shuffler_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_PICK, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  state_t            r_state, w_next;
  logic [7:0]        r_lfsr;
  logic [ADDR_W-1:0] r_k, r_i, r_j, r_vi;
  logic [ADDR_W-1:0] w_k, w_i, w_j, w_vi, w_rand, w_addr, w_data;
  logic              w_we, w_act, w_done;
  assign w_rand = r_lfsr[ADDR_W-1:0];
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_vi    <= '0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      r_k     <= w_k;
      r_i     <= w_i;
      r_j     <= w_j;
      r_vi    <= w_vi;
    end
  always_comb begin
    w_next = r_state;
    w_k    = r_k;
    w_i    = r_i;
    w_j    = r_j;
    w_vi   = r_vi;
    w_addr = '0;
    w_data = '0;
    w_we   = 1'b0;
    w_act  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_k    = '0;
        w_next = bus.i_Start ? S_INIT : S_IDLE;
      end
      S_INIT: begin
        w_addr = r_k;
        w_data = r_k;
        w_we   = 1'b1;
        w_act  = 1'b1;
        w_k    = r_k + ONE;
        w_i    = LAST;
        w_next = (r_k == LAST) ? S_PICK : S_INIT;
      end
      S_PICK: begin
        // rejection sampling: only accept an LFSR draw already inside 0..i
        w_act  = 1'b1;
        w_j    = (w_rand <= r_i) ? w_rand : r_j;
        w_next = (w_rand <= r_i) ? S_RD_I : S_PICK;
      end
      S_RD_I: begin
        w_act  = 1'b1;
        w_addr = r_i;
        w_next = S_RD_J;
      end
      S_RD_J: begin
        w_act  = 1'b1;
        w_addr = r_j;
        w_vi   = bus.i_RdData;
        w_next = S_WR_I;
      end
      S_WR_I: begin
        // read data now holds mem[j], requested during RD_J
        w_act  = 1'b1;
        w_addr = r_i;
        w_data = bus.i_RdData;
        w_we   = 1'b1;
        w_next = S_WR_J;
      end
      S_WR_J: begin
        w_act  = 1'b1;
        w_addr = r_j;
        w_data = r_vi;
        w_we   = 1'b1;
        w_i    = (r_i == ONE) ? r_i : r_i - ONE;
        w_next = (r_i == ONE) ? S_DONE : S_PICK;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  assign bus.o_ShufflerAddr = w_addr;
  assign bus.o_WrData       = w_data;
  assign bus.o_WrEn         = w_we;
  assign bus.o_ActShuffler  = w_act;
  assign bus.o_Done         = w_done;
endmodule
